// File: rtl/ppu_pkg.sv
// Shared PPU types and sizes.
// Tile-map entry layout and VRAM/line-buffer widths.
package ppu_pkg;

    localparam int TILRAM_AW = 10;
    localparam int PATRAM_AW = 12;
    localparam int VRAM_DW   = 64;
    localparam int LB_DW     = 36;

    typedef struct packed {
        logic       vflip;
        logic       hflip;
        logic [3:0] pal;
        logic [9:0] id;
    } tile_entry_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_DONE
    } fetch_state_t;

endpackage

// File: rtl/ppu_row_select.sv
// Picks one 32-bit pattern row out of a 64-bit word.
// Optionally mirrors it by reversing nibble order.
module ppu_row_select
    import ppu_pkg::*;
(
    input  logic [VRAM_DW-1:0] word,
    input  logic               half,
    input  logic               hflip,
    output logic [31:0]        row
);

    logic [31:0] sel;

    // half select, then nibble reversal for hflip
    always_comb begin
        sel = half ? word[63:32] : word[31:0];
        row = sel;
        if (hflip) begin
            for (int p = 0; p < 8; p++) begin
                row[4*p +: 4] = sel[4*(7-p) +: 4];
            end
        end
    end

endmodule

// File: rtl/ppu_bgr_fetch.sv
// Background scanline fetcher.
// Tile map read -> pattern read -> line-buffer write, one tile per cycle.
module ppu_bgr_fetch
    import ppu_pkg::*;
#(
    parameter int NUM_TILES = 41,
    parameter int RD_LAT    = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_fetch,
    input  logic [7:0]           i_row,
    input  logic [8:0]           i_scroll_x,
    input  logic [8:0]           i_scroll_y,
    output logic                 o_busy,
    output logic                 o_done,
    output logic [2:0]           o_fine_x,
    output logic [TILRAM_AW-1:0] o_tilram_addr_a,
    input  logic [VRAM_DW-1:0]   i_tilram_rddata_a,
    output logic                 o_tilram_wren_a,
    output logic [PATRAM_AW-1:0] o_patram_addr_b,
    input  logic [VRAM_DW-1:0]   i_patram_rddata_b,
    output logic                 o_patram_wren_b,
    output logic                 o_lb_wren,
    output logic [5:0]           o_lb_addr,
    output logic [LB_DW-1:0]     o_lb_data
);

    typedef struct packed {
        logic [5:0] k;
        logic [1:0] sub;
    } a_t;

    typedef struct packed {
        logic [5:0] k;
        logic [3:0] pal;
        logic       hflip;
        logic       half;
    } b_t;

    localparam logic [RD_LAT-1:0] VB_TOP = RD_LAT'(1) << (RD_LAT - 1);

    fetch_state_t state, state_nx;

    logic [5:0]        k;
    logic [5:0]        row_r;
    logic [2:0]        fine_y;
    logic [5:0]        sx_tile;
    logic [8:0]        ysum;
    logic [5:0]        col;
    logic              accept;
    logic              issue;
    logic              last_wr;

    logic [RD_LAT-1:0] va;
    logic [RD_LAT-1:0] vb;
    a_t                pa [RD_LAT];
    b_t                pb [RD_LAT];
    a_t                a_out;
    b_t                b_in;
    b_t                b_out;
    logic              va_out;
    logic              vb_out;
    tile_entry_t       entry;
    logic [2:0]        yp;
    logic [31:0]       row_px;

    assign ysum    = {1'b0, i_row} + i_scroll_y;
    assign col     = sx_tile + k;
    assign accept  = (state == S_IDLE) && i_fetch;
    assign issue   = (state == S_ISSUE);
    assign a_out   = pa[RD_LAT-1];
    assign b_out   = pb[RD_LAT-1];
    assign va_out  = va[RD_LAT-1];
    assign vb_out  = vb[RD_LAT-1];
    assign last_wr = vb_out && (va == '0) && ((vb & ~VB_TOP) == '0);

    assign o_tilram_wren_a = 1'b0;
    assign o_patram_wren_b = 1'b0;
    assign o_tilram_addr_a = {row_r, col[5:2]};
    assign o_busy          = (state == S_ISSUE) || (state == S_DRAIN);
    assign o_done          = (state == S_DONE);

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    // next-state logic
    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE:  if (i_fetch) state_nx = S_ISSUE;
            S_ISSUE: if (k == 6'(NUM_TILES - 1)) state_nx = S_DRAIN;
            S_DRAIN: if (last_wr) state_nx = S_DONE;
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // latch scroll/row at accept and step the tile counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k        <= '0;
            row_r    <= '0;
            fine_y   <= '0;
            sx_tile  <= '0;
            o_fine_x <= '0;
        end else if (accept) begin
            k        <= '0;
            row_r    <= ysum[8:3];
            fine_y   <= ysum[2:0];
            sx_tile  <= i_scroll_x[8:3];
            o_fine_x <= i_scroll_x[2:0];
        end else if (issue) begin
            k <= k + 6'd1;
        end
    end

    // decode the returned tile entry into a pattern request
    always_comb begin
        entry = tile_entry_t'(i_tilram_rddata_a[16*a_out.sub +: 16]);
        yp    = entry.vflip ? ~fine_y : fine_y;
        b_in  = '{k: a_out.k, pal: entry.pal,
                  hflip: entry.hflip, half: yp[0]};
        o_patram_addr_b = va_out ? {entry.id, yp[2:1]} : '0;
    end

    // delay lines matching the two VRAM read latencies
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            va <= '0;
            vb <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                pa[i] <= '0;
                pb[i] <= '0;
            end
        end else begin
            va[0] <= issue;
            pa[0] <= '{k: k, sub: col[1:0]};
            vb[0] <= va_out;
            pb[0] <= b_in;
            for (int i = 1; i < RD_LAT; i++) begin
                va[i] <= va[i-1];
                pa[i] <= pa[i-1];
                vb[i] <= vb[i-1];
                pb[i] <= pb[i-1];
            end
        end
    end

    ppu_row_select u_row_select (
        .word  (i_patram_rddata_b),
        .half  (b_out.half),
        .hflip (b_out.hflip),
        .row   (row_px)
    );

    // line-buffer write port, zero when not writing
    always_comb begin
        o_lb_wren = vb_out;
        o_lb_addr = vb_out ? b_out.k : '0;
        o_lb_data = vb_out ? {b_out.pal, row_px} : '0;
    end

endmodule

// File: tb/tb_ppu_bgr_fetch.sv
// Scoreboard bench for ppu_bgr_fetch.
// Two-cycle VRAM models; expected writes derived from the map contents.
module tb_ppu_bgr_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_fetch = 1'b0;
    logic [7:0]  i_row = '0;
    logic [8:0]  i_scroll_x = '0;
    logic [8:0]  i_scroll_y = '0;
    logic        o_busy, o_done;
    logic [2:0]  o_fine_x;
    logic [9:0]  o_tilram_addr_a;
    logic [63:0] i_tilram_rddata_a = '0;
    logic        o_tilram_wren_a;
    logic [11:0] o_patram_addr_b;
    logic [63:0] i_patram_rddata_b = '0;
    logic        o_patram_wren_b;
    logic        o_lb_wren;
    logic [5:0]  o_lb_addr;
    logic [35:0] o_lb_data;

    ppu_bgr_fetch dut (
        .clk               (clk),
        .rst               (rst),
        .i_fetch           (i_fetch),
        .i_row             (i_row),
        .i_scroll_x        (i_scroll_x),
        .i_scroll_y        (i_scroll_y),
        .o_busy            (o_busy),
        .o_done            (o_done),
        .o_fine_x          (o_fine_x),
        .o_tilram_addr_a   (o_tilram_addr_a),
        .i_tilram_rddata_a (i_tilram_rddata_a),
        .o_tilram_wren_a   (o_tilram_wren_a),
        .o_patram_addr_b   (o_patram_addr_b),
        .i_patram_rddata_b (i_patram_rddata_b),
        .o_patram_wren_b   (o_patram_wren_b),
        .o_lb_wren         (o_lb_wren),
        .o_lb_addr         (o_lb_addr),
        .o_lb_data         (o_lb_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          slot;
        logic [35:0] data;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    logic [63:0] tmem [1024];
    logic [63:0] pmem [4096];
    logic [9:0]  ta_r = '0;
    logic [11:0] pa_r = '0;
    logic [35:0] got_data [41];
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;
    int          wr_cnt = 0;
    int          done_cnt = 0;
    int          done_cyc = 0;
    logic        done_busy = 1'b0;
    int          t0;

    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        ta_r              <= o_tilram_addr_a;
        i_tilram_rddata_a <= tmem[ta_r];
        pa_r              <= o_patram_addr_b;
        i_patram_rddata_b <= pmem[pa_r];
    end

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] get_entry(int idx);
        logic [63:0] w;
        w = tmem[idx / 4];
        return w[16*(idx % 4) +: 16];
    endfunction

    task automatic set_entry(int idx, logic [15:0] v);
        tmem[idx / 4][16*(idx % 4) +: 16] = v;
    endtask

    task automatic set_prow(int ri, logic [31:0] v);
        pmem[ri / 2][32*(ri % 2) +: 32] = v;
    endtask

    task automatic push_expected(int row, int sx, int sy, int ts);
        int y, r, fy, c, idx, yp, ri;
        logic [15:0] e;
        logic [63:0] w;
        logic [31:0] rw, rx;
        y  = (row + sy) % 512;
        r  = y / 8;
        fy = y % 8;
        for (int k = 0; k < 41; k++) begin
            c   = (sx / 8 + k) % 64;
            idx = r * 64 + c;
            e   = get_entry(idx);
            yp  = e[15] ? 7 - fy : fy;
            ri  = int'(e[9:0]) * 8 + yp;
            w   = pmem[ri / 2];
            rw  = w[32*(ri % 2) +: 32];
            rx  = rw;
            if (e[14])
                for (int p = 0; p < 8; p++) rx[4*p +: 4] = rw[4*(7-p) +: 4];
            sb.push_back('{k, {e[13:10], rx}, ts + 5 + k});
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            check("ro_wren", 64'(o_tilram_wren_a | o_patram_wren_b), 0);
            if (o_lb_wren) begin
                wr_cnt++;
                if (sb.size() == 0) begin
                    check("unexp_wr", 64'(o_lb_wren), 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("lb_addr", 64'(o_lb_addr), 64'(e.slot));
                    check("lb_data", 64'(o_lb_data), 64'(e.data));
                    check("lb_cyc", 64'(cyc), 64'(e.cyc));
                    if (o_lb_addr < 41) got_data[o_lb_addr] = o_lb_data;
                end
            end
            if (o_done) begin
                done_cnt++;
                done_cyc  = cyc;
                done_busy = o_busy;
            end
        end
    end

    task automatic run_fetch(int row, int sx, int sy, output int ts);
        @(negedge clk);
        i_row      = 8'(row);
        i_scroll_x = 9'(sx);
        i_scroll_y = 9'(sy);
        i_fetch    = 1'b1;
        ts         = cyc;
        wr_cnt     = 0;
        done_cnt   = 0;
        push_expected(row, sx, sy, ts);
        @(negedge clk);
        i_fetch = 1'b0;
        check("busy_t1", 64'(o_busy), 1);
    endtask

    task automatic wait_done(int ts);
        int n;
        n = 0;
        while (done_cnt == 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        check("done_cnt", 64'(done_cnt), 1);
        check("done_cyc", 64'(done_cyc), 64'(ts + 46));
        check("busy_done", 64'(done_busy), 0);
        check("wr_cnt", 64'(wr_cnt), 41);
        check("sb_empty", 64'(sb.size()), 0);
    endtask

    initial begin
        for (int i = 0; i < 4096; i++)
            set_entry(i, {2'b00, 4'(i), 10'(i)});
        for (int ri = 0; ri < 8192; ri++)
            set_prow(ri, {1'b0, 3'(ri), 18'h0, 10'(ri / 8)});

        repeat (3) @(negedge clk);
        check("rst_busy", 64'(o_busy), 0);
        check("rst_done", 64'(o_done), 0);
        check("rst_wren", 64'(o_lb_wren), 0);
        check("rst_lbaddr", 64'(o_lb_addr), 0);
        check("rst_lbdata", 64'(o_lb_data), 0);
        check("rst_finex", 64'(o_fine_x), 0);
        check("rst_taddr", 64'(o_tilram_addr_a), 0);
        check("rst_paddr", 64'(o_patram_addr_b), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        run_fetch(0, 0, 0, t0);
        wait_done(t0);
        check("basic_s5", 64'(got_data[5]), {28'h0, 4'd5, 32'd5});
        check("basic_s40", 64'(got_data[40]), {28'h0, 4'd8, 32'd40});

        set_entry(0, {1'b0, 1'b1, 4'h0, 10'd0});
        set_prow(0, 32'h7654_3210);
        run_fetch(0, 0, 0, t0);
        wait_done(t0);
        check("hflip", 64'(got_data[0][31:0]), 32'h0123_4567);

        set_entry(0, {1'b1, 1'b0, 4'h0, 10'd0});
        set_prow(7, 32'hCAFE_0007);
        run_fetch(0, 0, 0, t0);
        wait_done(t0);
        check("vflip", 64'(got_data[0][31:0]), 32'hCAFE_0007);
        set_entry(0, 16'h0000);
        set_prow(0, 32'h0);

        run_fetch(0, 509, 0, t0);
        wait_done(t0);
        check("fine_x", 64'(o_fine_x), 5);
        check("cwrap_s0", 64'(got_data[0]), {28'h0, 4'd15, 32'd63});
        check("cwrap_s1", 64'(got_data[1]), {28'h0, 4'd0, 32'd0});

        run_fetch(200, 0, 400, t0);
        wait_done(t0);
        check("rwrap_s0", 64'(got_data[0]), {28'h0, 4'd0, 32'd704});
        check("rwrap_s1", 64'(got_data[1]), {28'h0, 4'd1, 32'd705});

        run_fetch(8, 16, 0, t0);
        while (cyc < t0 + 10) @(negedge clk);
        i_row   = 8'd100;
        i_fetch = 1'b1;
        @(negedge clk);
        i_fetch = 1'b0;
        wait_done(t0);
        repeat (50) @(posedge clk);
        check("busy_ign_done", 64'(done_cnt), 1);
        check("busy_ign_wr", 64'(wr_cnt), 41);

        run_fetch(16, 40, 3, t0);
        wait_done(t0);

        run_fetch(3, 100, 7, t0);
        while (cyc < t0 + 20) @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_mid_busy", 64'(o_busy), 0);
        check("rst_mid_wren", 64'(o_lb_wren), 0);
        sb.delete();
        wr_cnt   = 0;
        done_cnt = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (60) @(posedge clk);
        check("rst_no_wr", 64'(wr_cnt), 0);
        check("rst_no_done", 64'(done_cnt), 0);

        run_fetch(239, 511, 511, t0);
        wait_done(t0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ppu_bgr_fetch.md
# ppu_bgr_fetch

Background scanline fetcher for the PPU. On a start pulse it reads 41 tile-map entries from the PPU-facing tile RAM and the matching 8-pixel pattern rows from the PPU-facing pattern RAM, then writes flip-corrected rows plus palette into the background line buffer. It is the read-side client of the PPU-facing VRAM: port A of tile RAM and port B of pattern RAM, with no writes.

## Interface
Parameters:
- NUM_TILES, 41, tiles fetched per scanline (320 px / 8, plus 1 for fine scroll).
- RD_LAT, 2, VRAM read latency in cycles. Address and q are both registered. This value is fixed and used only for pipeline sizing.

Ports:
- clk  in  1  system clock; the only clock.
- rst  in  1  reset, asynchronous, active-high.
- i_fetch  in  1  start pulse; accepted only in IDLE.
- i_row  in  8  screen scanline 0..239.
- i_scroll_x  in  9  background X scroll in pixels, mod 512.
- i_scroll_y  in  9  background Y scroll in pixels, mod 512.
- o_busy  out  1  high from accept until the last line-buffer write.
- o_done  out  1  one-cycle pulse in the cycle after the last write.
- o_fine_x  out  3  i_scroll_x[2:0] latched at accept.
- o_tilram_addr_a  out  10  tile RAM word address.
- i_tilram_rddata_a  in  64  tile RAM read data.
- o_tilram_wren_a  out  1  tied 0.
- o_patram_addr_b  out  12  pattern RAM word address.
- i_patram_rddata_b  in  64  pattern RAM read data.
- o_patram_wren_b  out  1  tied 0.
- o_lb_wren  out  1  line-buffer write strobe.
- o_lb_addr  out  6  line-buffer slot 0..40.
- o_lb_data  out  36  {palette[3:0], pixels[31:0]}; pixel p occupies nibble [4p+3:4p], with pixel 0 leftmost.

## Operation
- Tile map: 64x64 entries of 16 bits, four per 64-bit word. The entry at index i is in word i>>2, bits [16*i[1:0] +: 16].
- Entry fields: [9:0] tile id, [13:10] palette, [14] hflip, [15] vflip.
- Pattern: each 8-pixel row is 32 bits (4 bpp), two rows per word. Row index ri = tile_id*8 + y', located in word ri>>1, bits [32*ri[0] +: 32].
- On accept, latch the inputs. Then compute:
  - y = (i_row + i_scroll_y) mod 512
  - tile row r = y[8:3], fine_y = y[2:0]
- For k = 0..NUM_TILES-1:
  - column c = (scroll_x[8:3] + k) mod 64
  - tile index = r*64 + c
- vflip: y' = 7 - fine_y, otherwise y' = fine_y.
- hflip: reverse the nibble order of the 32-bit row.
- The fetch is fully pipelined. One tile address is issued per cycle. The pattern address is issued RD_LAT cycles later. The line-buffer write happens RD_LAT cycles after that, with o_lb_addr = k.
- FSM states:
  - IDLE --i_fetch--> ISSUE.
  - ISSUE: NUM_TILES cycles, k increments each cycle; then DRAIN.
  - DRAIN: runs until the last write, then DONE.
  - DONE: one cycle, then IDLE.
- i_fetch outside IDLE is ignored; it is not queued.

## Timing
- Reset values: all outputs 0 and state IDLE. In-flight pipeline valids clear.
- Accept in cycle T:
  - o_busy = 1 from T+1.
  - First tile address is issued in T+1.
  - First o_lb_wren is in T+1+2*RD_LAT = T+5.
  - Last write is in T+45.
  - o_done pulses in T+46; o_busy is 0 in T+46.
- Writes are strictly consecutive, k = 0..40, with no gaps.
- Column wrap: c wraps 63→0 within a scanline, e.g. scroll_x = 504 gives c = 63, 0, 1, ...
- Row wrap: i_row + i_scroll_y ≥ 512 wraps mod 512.
- Reset asserted mid-fetch: immediate return to IDLE. No further o_lb_wren, and no o_done.
- i_fetch in the same cycle as o_done is ignored. It is accepted only in IDLE, so the earliest re-accept is T+47.
- Address outputs may hold stale values when idle. o_lb_data is don't-care when o_lb_wren = 0.

## Structure
- Shared ppu package holds:
  - the tile-entry struct (id, palette, hflip, vflip)
  - TILRAM_AW = 10, PATRAM_AW = 12, VRAM_DW = 64
  - the line-buffer data width of 36
- Sub-module ppu_row_select (combinational): takes the 64-bit pattern word, ri[0] and hflip, and returns the 32-bit row.
- The top level connects the ports to the PPU-facing VRAM interface signals.

## Test plan
- Basic fetch: scroll 0, row 0. Entry k = {pal=k[3:0], id=k}; pattern row 0 of tile n = 32'h0000_0000 + n. Expect 41 writes, slot k with data {k[3:0], 32'h0+k}; o_done at T+46.
- Flips: entry 0 with hflip=1, pattern row 0 = 32'h7654_3210 → o_lb_data[31:0] = 32'h0123_4567. The same entry with vflip=1 at fine_y = 0 reads pattern row 7.
- Wrap: scroll_x = 504 → slot 0 reads column 63 and slot 1 reads column 0. i_row = 200 with scroll_y = 400 → y = 88, so r = 11 and fine_y = 0.
- Busy handling: a second i_fetch at T+10 is ignored, giving exactly 41 writes and one o_done. The fetch starts again when i_fetch is pulsed in IDLE.
- Reset: rst asserted at T+20 → o_busy drops asynchronously, with no writes and no o_done afterwards. A new fetch after release completes normally.
- Read-only: o_tilram_wren_a and o_patram_wren_b stay 0 throughout all scenarios.
